frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Batch controller placed in front of the peak detector. It cuts a continuous complex sample stream into BATCH_SIZE-long frames with sop/eop/valid framing and pulses the detector's reset before each frame. After each frame it withholds new frames until the detector reports completion, and it counts completed frames, dropped samples and completion timeouts.

## Interface
Parameters:
- BATCH_SIZE, 1024: samples per frame; power of two, ≥ 2.
- DATA_WIDTH, 20: bits per real/imaginary part.
- CNT_WIDTH, 16: width of the frame and drop counters.
- TIMEOUT, 4096: maximum WAIT cycles allowed for det_done; ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high: run frames back to back; low: stop after the current frame.
- sink_valid  in  1  input sample valid.
- sink_re  in  DATA_WIDTH  real part of the input sample.
- sink_im  in  DATA_WIDTH  imaginary part of the input sample.
- det_done  in  1  one-cycle pulse: the detector has emitted its last peak.
- det_reset  out  1  one-cycle pulse that resets the detector.
- source_sop  out  1  first sample of a frame.
- source_eop  out  1  last sample of a frame.
- source_valid  out  1  output sample valid.
- source_re  out  DATA_WIDTH  forwarded real part.
- source_im  out  DATA_WIDTH  forwarded imaginary part.
- frame_count  out  CNT_WIDTH  completed frames; saturating.
- drop_count  out  CNT_WIDTH  valid input samples that were not forwarded; saturating.
- timeout_err  out  1  sticky; set on any WAIT timeout.
- busy  out  1  high whenever the state is not IDLE.

## Operation
States: IDLE, CLEAR, STREAM, WAIT.

- **IDLE**
  - Samples are ignored and not counted as dropped.
  - If enable = 1, go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - det_reset = 1.
  - Position counter pos is set to 0.
  - A valid sample in this cycle is dropped and drop_count increments.
  - Next state is always STREAM.
- **STREAM**
  - Each sink_valid sample is forwarded: source_valid = 1, data copied.
  - source_sop = 1 when pos = 0; source_eop = 1 when pos = BATCH_SIZE-1.
  - pos increments only on valid samples. Gaps in sink_valid are allowed and hold pos.
  - The eop sample moves the state to WAIT, with timer set to 0.
  - enable going low mid-frame does not truncate the frame.
- **WAIT**
  - Valid samples are dropped and drop_count increments once per sample.
  - timer increments every cycle.
  - det_done = 1: frame_count increments; next state is CLEAR if enable = 1, else IDLE.
  - If timer = TIMEOUT-1 and det_done = 0: set timeout_err; frame_count is unchanged; next state is CLEAR if enable = 1, else IDLE.
  - det_done and the timeout on the same cycle: det_done wins and timeout_err is not set.
- **det_done outside WAIT:** ignored.
- **Counters:** frame_count and drop_count saturate at 2^CNT_WIDTH-1 and never wrap. pos wraps naturally (log2(BATCH_SIZE) bits).
- **timeout_err:** cleared only by reset.

## Timing
- **Reset values:** every output is 0; the state is IDLE; pos and timer are 0.
- **Reset mid-operation:** any frame in flight is abandoned with no eop. Outputs are 0 on the cycle after reset is sampled.
- **Output registers:** all outputs are registered.
  - Sample forwarding latency is 1 cycle: a sample valid at edge n appears at source_* after edge n.
  - source_re/source_im hold their last value when source_valid = 0.
- **Start-up:** enable sampled high in IDLE at edge n. det_reset is high for the cycle after edge n (CLEAR). A sample valid at edge n+2 is the first one accepted into STREAM (pos = 0).
- **Frame end:** the eop sample is accepted at edge m. WAIT begins after edge m. A sample valid at edge m+1 is dropped.
- **Frame to frame:** det_done sampled at edge k moves the state to CLEAR after edge k. frame_count updates after edge k. The next frame's first sample is accepted at edge k+2 or later.
- **Frame pacing:** with continuous input, at least 2 samples are dropped between frames (the first WAIT cycle plus CLEAR).
- **Timeout:** exits WAIT after the TIMEOUT-th WAIT cycle; timeout_err is visible after that edge.

## Test plan
Bench settings: BATCH_SIZE = 8, TIMEOUT = 16, CNT_WIDTH = 4.

- **Basic frame:** enable = 1 with continuous valid ramp data 0,1,2,…, and det_done pulsed 3 cycles after eop.
  - det_reset pulses once.
  - 8 samples are forwarded with sop on the first and eop on the 8th.
  - WAIT lasts 4 cycles (the pulse lands on the 4th WAIT cycle), so drop_count = 4 (the 4 WAIT samples); after the following CLEAR it reads 5.
  - frame_count = 1, then the next frame starts.
- **Gapped input:** sink_valid toggles every cycle → 8 forwarded samples, pos advances only on valid samples, and sop/eop are placed correctly.
- **Enable drop mid-frame:** enable falls after the 3rd sample → the frame completes all 8 samples; after det_done the state goes to IDLE, busy = 0, and no further det_reset occurs.
- **Timeout:** det_done is never asserted → after 16 WAIT cycles, timeout_err = 1 and frame_count = 0. The state goes to CLEAR and timeout_err stays 1 in the next frame.
- **Edge cases:**
  - det_done on the same cycle as the timeout → frame_count increments and timeout_err = 0.
  - det_done during STREAM → ignored.
  - 20 completed frames → frame_count saturates at 15.
- **Reset mid-STREAM:** reset at the 5th sample → all outputs are 0 on the next cycle with no eop. After reset is released with enable = 1, det_reset pulses and a full 8-sample frame follows.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: cuts a sample stream into BATCH_SIZE frames, pulses the detector reset
// before each frame and waits for det_done (or a timeout) between frames.
module frame_sequencer #(
  parameter int BATCH_SIZE = 1024,
  parameter int DATA_WIDTH = 20,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sink_valid,
  input  logic [DATA_WIDTH-1:0] sink_re,
  input  logic [DATA_WIDTH-1:0] sink_im,
  input  logic                  det_done,
  output logic                  det_reset,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic                  source_valid,
  output logic [DATA_WIDTH-1:0] source_re,
  output logic [DATA_WIDTH-1:0] source_im,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  timeout_err,
  output logic                  busy
);
  localparam int PW = $clog2(BATCH_SIZE);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, WAIT} state_t;
  state_t state, state_n;
  logic [PW-1:0] pos;
  logic [TW-1:0] timer;
  logic take, last, drop, timed_out, done;
  always_comb begin
    take = state == STREAM && sink_valid;
    last = take && pos == PW'(BATCH_SIZE - 1);
    drop = sink_valid && (state == CLEAR || state == WAIT);
    done = state == WAIT && det_done;
    timed_out = state == WAIT && !det_done && timer == TW'(TIMEOUT - 1);
    state_n = state;
    unique case (state)
      IDLE:   state_n = enable ? CLEAR : IDLE;
      CLEAR:  state_n = STREAM;
      STREAM: state_n = last ? WAIT : STREAM;
      WAIT:   state_n = (done || timed_out) ? (enable ? CLEAR : IDLE) : WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pos          <= '0;
      timer        <= '0;
      det_reset    <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_valid <= 1'b0;
      source_re    <= '0;
      source_im    <= '0;
      frame_count  <= '0;
      drop_count   <= '0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      busy         <= state_n != IDLE;
      det_reset    <= state_n == CLEAR;
      source_valid <= take;
      source_sop   <= take && pos == '0;
      source_eop   <= last;
      if (take) begin
        source_re <= sink_re;
        source_im <= sink_im;
      end
      pos   <= state == CLEAR ? '0 : pos + PW'(take);
      // timer rests at 0 outside WAIT, so it is already cleared on WAIT entry
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (done && frame_count != '1) frame_count <= frame_count + 1'b1;
      if (timed_out) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed and randomized frames checked every cycle against a behavioural model.
module tb_frame_sequencer;
  localparam int B = 8, T = 16, CW = 4, DW = 20;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_STREAM = 2, M_WAIT = 3;
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, sink_valid = 1'b0, det_done = 1'b0;
  logic [DW-1:0] sink_re = '0, sink_im = '0;
  logic det_reset, source_sop, source_eop, source_valid, timeout_err, busy;
  logic [DW-1:0] source_re, source_im;
  logic [CW-1:0] frame_count, drop_count;
  int checks = 0, errors = 0;
  int ramp = 0;
  int m_mode = 0, m_pos = 0, m_wait = 0, m_frames = 0, m_drops = 0;
  bit m_err = 0;
  bit e_det_reset = 0, e_sop = 0, e_eop = 0, e_valid = 0, e_busy = 0;
  logic [DW-1:0] e_re = '0, e_im = '0;

  always #5 clk = ~clk;

  frame_sequencer #(.BATCH_SIZE(B), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sink_valid(sink_valid),
    .sink_re(sink_re), .sink_im(sink_im), .det_done(det_done), .det_reset(det_reset),
    .source_sop(source_sop), .source_eop(source_eop), .source_valid(source_valid),
    .source_re(source_re), .source_im(source_im), .frame_count(frame_count),
    .drop_count(drop_count), .timeout_err(timeout_err), .busy(busy)
  );

  function automatic int sat(input int v);
    return v > (1 << CW) - 1 ? (1 << CW) - 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: frame phase plus sample/wait counters, advanced once per clock.
  task automatic model_step();
    e_sop = 0; e_eop = 0; e_valid = 0;
    if (reset) begin
      m_mode = M_IDLE; m_pos = 0; m_wait = 0; m_frames = 0; m_drops = 0; m_err = 0;
      e_re = '0; e_im = '0;
    end else if (m_mode == M_IDLE) begin
      if (enable) m_mode = M_CLEAR;
    end else if (m_mode == M_CLEAR) begin
      m_pos = 0;
      if (sink_valid) m_drops = sat(m_drops + 1);
      m_mode = M_STREAM;
    end else if (m_mode == M_STREAM) begin
      if (sink_valid) begin
        e_valid = 1; e_re = sink_re; e_im = sink_im;
        e_sop = m_pos == 0;
        e_eop = m_pos == B - 1;
        m_pos = (m_pos + 1) % B;
        if (e_eop) begin m_mode = M_WAIT; m_wait = 0; end
      end
    end else begin
      if (sink_valid) m_drops = sat(m_drops + 1);
      if (det_done) begin
        m_frames = sat(m_frames + 1);
        m_mode = enable ? M_CLEAR : M_IDLE;
      end else if (m_wait == T - 1) begin
        m_err = 1;
        m_mode = enable ? M_CLEAR : M_IDLE;
      end
      m_wait++;
    end
    e_det_reset = m_mode == M_CLEAR;
    e_busy = m_mode != M_IDLE;
  endtask

  task automatic compare_all();
    chk("det_reset", det_reset, e_det_reset);
    chk("sop", source_sop, e_sop);
    chk("eop", source_eop, e_eop);
    chk("valid", source_valid, e_valid);
    chk("re", source_re, e_re);
    chk("im", source_im, e_im);
    chk("frame_count", frame_count, m_frames);
    chk("drop_count", drop_count, m_drops);
    chk("timeout_err", timeout_err, m_err);
    chk("busy", busy, e_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic drive(input bit v);
    sink_valid = v;
    sink_re = DW'(ramp);
    sink_im = DW'($urandom);
    if (v) ramp++;
  endtask

  // vmode: 1 continuous, 2 alternating, 3 random valid with stray det_done during the frame
  task automatic run_frame(input int vmode, input int done_delay, input int en_drop_at);
    int n = 0, acc = 0, since = 0;
    do begin
      drive(vmode == 1 ? 1'b1 : vmode == 2 ? (n % 2 == 0) : 1'($urandom_range(0, 1)));
      det_done = vmode == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (en_drop_at >= 0 && acc >= en_drop_at) enable = 0;
      tick();
      n++;
      acc += int'(e_valid);
    end while (!e_eop && n < 200);
    checks++;
    assert (e_eop) else begin errors++; $error("FAIL eop_bound observed %0d cycles expected eop", n); end
    do begin
      since++;
      det_done = since == done_delay + 1;
      drive(1'($urandom_range(0, 1)));
      tick();
    end while (m_mode == M_WAIT && since < 40);
    det_done = 0;
    checks++;
    assert (m_mode != M_WAIT) else begin errors++; $error("FAIL wait_bound observed %0d cycles expected exit", since); end
  endtask

  initial begin
    int n;
    drive(0);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_valid", source_valid, 0);
    reset = 0;
    tick();
    // basic frame with ramp data
    enable = 1;
    tick();
    chk("basic_clear", det_reset, 1);
    tick();
    chk("basic_clear_end", det_reset, 0);
    for (int i = 0; i < B; i++) begin
      drive(1);
      tick();
      chk("basic_sop", source_sop, i == 0);
      chk("basic_eop", source_eop, i == B - 1);
      chk("basic_re", source_re, i);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1);
      det_done = i == 3;
      tick();
    end
    det_done = 0;
    chk("basic_drop", drop_count, 4);
    chk("basic_frames", frame_count, 1);
    chk("basic_next_clear", det_reset, 1);
    drive(1);
    tick();
    chk("basic_drop_clear", drop_count, 5);
    chk("basic_next_stream", busy, 1);
    // gapped input
    run_frame(2, 2, -1);
    chk("gap_frames", frame_count, 2);
    // enable falls after the 3rd sample
    run_frame(1, 1, 3);
    chk("endrop_frames", frame_count, 3);
    chk("endrop_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1);
      tick();
      chk("endrop_no_reset", det_reset, 0);
    end
    // timeout from a fresh start
    reset = 1; tick(); reset = 0;
    enable = 1;
    run_frame(1, -1, -1);
    chk("to_err", timeout_err, 1);
    chk("to_frames", frame_count, 0);
    chk("to_clear", det_reset, 1);
    run_frame(3, 4, -1);
    chk("to_sticky", timeout_err, 1);
    chk("to_frames_after", frame_count, 1);
    // det_done coincident with timeout
    reset = 1; tick(); reset = 0;
    run_frame(1, T - 1, -1);
    chk("coinc_err", timeout_err, 0);
    chk("coinc_frames", frame_count, 1);
    // saturation with random input and stray det_done during STREAM
    for (int i = 0; i < 20; i++) run_frame(3, $urandom_range(0, 12), -1);
    chk("sat_frames", frame_count, 15);
    chk("sat_drops", drop_count, 15);
    // reset on the 5th sample of a frame
    n = 0;
    while (!(m_mode == M_STREAM && m_pos == 4) && n < 100) begin
      drive(1);
      tick();
      n++;
    end
    checks++;
    assert (n < 100) else begin errors++; $error("FAIL midreset_bound observed %0d expected <100", n); end
    reset = 1;
    drive(1);
    tick();
    chk("midrst_eop", source_eop, 0);
    chk("midrst_valid", source_valid, 0);
    chk("midrst_re", source_re, 0);
    chk("midrst_frames", frame_count, 0);
    chk("midrst_busy", busy, 0);
    reset = 0;
    tick();
    chk("midrst_clear", det_reset, 1);
    run_frame(1, 2, -1);
    chk("midrst_frames_after", frame_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
